uart_rx_oversampled: RTL and testbench

- Serial receive end of the board UART link.
- Recovers 8N1 bytes from the asynchronous rxd line using an internal fractional-accumulator oversampling tick (BAUD_RATE × OVERSAMPLING).
- Emits each byte with a one-cycle valid strobe, plus line-idle and end-of-packet indications.
- Pairs with the existing transmit path.

---
 rtl/uart_rx_oversampled.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with a fractional-accumulator oversampling tick and a majority-filtered input.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_rx_oversampled #(
  parameter int unsigned CLK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned OVERSAMPLING  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       framing_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       rx_idle,
  output logic       rx_endofpacket
);

  localparam int unsigned AccWidth   = $clog2(CLK_FREQUENCY / BAUD_RATE) + 8;
  // Numerator is shifted by at most 10 bits so the rounding divide stays within 32 bits.
  localparam int unsigned ShiftLimit = AccWidth - 10;
  localparam int unsigned BaudOs     = BAUD_RATE * OVERSAMPLING;
  localparam int unsigned Inc        = ((BaudOs << (AccWidth - ShiftLimit)) +
                                        (CLK_FREQUENCY >> (ShiftLimit + 1))) /
                                       (CLK_FREQUENCY >> ShiftLimit);
  localparam logic [AccWidth:0] IncW = (AccWidth + 1)'(Inc);

  localparam int unsigned OsW      = $clog2(OVERSAMPLING);
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLING - 1);
  // The detecting tick counts as the first of the half-bit wait.
  localparam logic [OsW-1:0] MidCnt = OsW'(OVERSAMPLING / 2 - 2);
  localparam int unsigned GapW     = $clog2(2 * OVERSAMPLING) + 1;
  localparam logic [GapW-1:0] GapFull = GapW'(2 * OVERSAMPLING);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  logic [AccWidth:0] r_acc;
  logic [1:0]        r_sync;
  logic [1:0]        r_filt;
  state_e            r_state, w_state_d;
  logic [OsW-1:0]    r_os_cnt, w_os_cnt_d;
  logic [2:0]        r_bit_idx, w_bit_idx_d;
  logic [7:0]        r_shift, w_shift_d;
  logic [7:0]        r_data, w_data_d;
  logic              r_ready, w_ready_d;
  logic              r_ferr, w_ferr_d;
  logic [GapW-1:0]   r_gap, w_gap_d;
  logic              r_idle, w_idle_d;
  logic              r_eop, w_eop_d;
  logic              r_byte_seen, w_byte_seen_d;
`ifdef UART_RX_PARITY_EN
  logic              r_par, w_par_d;
  logic              r_perr, w_perr_d;
`endif

  logic w_tick;
  logic w_rxf;

  assign w_tick = r_acc[AccWidth];
  // Majority over the two previous tick samples and the one being taken now.
  assign w_rxf  = (r_filt[1] & r_filt[0]) | (r_filt[1] & r_sync[1]) | (r_filt[0] & r_sync[1]);

  always_comb begin
    w_state_d   = r_state;
    w_os_cnt_d  = r_os_cnt;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_data_d    = r_data;
    w_ready_d   = 1'b0;
    w_ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_d     = r_par;
    w_perr_d    = 1'b0;
`endif
    if (w_tick) begin
      unique case (r_state)
        StIdle: begin
          if (!w_rxf) begin
            w_state_d  = StStart;
            w_os_cnt_d = '0;
          end
        end
        StStart: begin
          if (r_os_cnt == MidCnt) begin
            w_os_cnt_d = '0;
            if (w_rxf) begin
              w_state_d = StIdle;
            end else begin
              w_state_d   = StData;
              w_bit_idx_d = '0;
            end
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_os_cnt == OsLast) begin
            w_os_cnt_d  = '0;
            w_shift_d   = {w_rxf, r_shift[7:1]};
            w_bit_idx_d = r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_d = StParity;
`else
              w_state_d = StStop;
`endif
            end
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (r_os_cnt == OsLast) begin
            w_os_cnt_d = '0;
            w_par_d    = w_rxf;
            w_state_d  = StStop;
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
`endif
        StStop: begin
          if (r_os_cnt == OsLast) begin
            w_os_cnt_d = '0;
            if (w_rxf) begin
              w_data_d  = r_shift;
              w_ready_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              w_perr_d  = (^r_shift) != r_par;
`endif
              w_state_d = StIdle;
            end else begin
              w_ferr_d  = 1'b1;
              w_state_d = StWaitHigh;
            end
          end else begin
            w_os_cnt_d = r_os_cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          if (w_rxf) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end

    // Gap only counts ticks spent fully inside IDLE, so the re-entry tick is excluded.
    w_gap_d = r_gap;
    if (w_state_d != StIdle) begin
      w_gap_d = '0;
    end else if (w_tick && (r_state == StIdle) && (r_gap != GapFull)) begin
      w_gap_d = r_gap + 1'b1;
    end
    w_idle_d      = (w_state_d == StIdle) && (w_gap_d == GapFull);
    w_eop_d       = w_idle_d && !r_idle && r_byte_seen;
    w_byte_seen_d = w_eop_d ? 1'b0 : (r_byte_seen | w_ready_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sync      <= 2'b11;
      r_filt      <= 2'b11;
      r_state     <= StIdle;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_ferr      <= 1'b0;
      r_gap       <= '0;
      r_idle      <= 1'b0;
      r_eop       <= 1'b0;
      r_byte_seen <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par       <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_acc       <= {1'b0, r_acc[AccWidth-1:0]} + IncW;
      r_sync      <= {r_sync[0], rxd};
      if (w_tick) r_filt <= {r_filt[0], r_sync[1]};
      r_state     <= w_state_d;
      r_os_cnt    <= w_os_cnt_d;
      r_bit_idx   <= w_bit_idx_d;
      r_shift     <= w_shift_d;
      r_data      <= w_data_d;
      r_ready     <= w_ready_d;
      r_ferr      <= w_ferr_d;
      r_gap       <= w_gap_d;
      r_idle      <= w_idle_d;
      r_eop       <= w_eop_d;
      r_byte_seen <= w_byte_seen_d;
`ifdef UART_RX_PARITY_EN
      r_par       <= w_par_d;
      r_perr      <= w_perr_d;
`endif
    end
  end

  assign rx_data        = r_data;
  assign rx_data_ready  = r_ready;
  assign framing_error  = r_ferr;
  assign rx_idle        = r_idle;
  assign rx_endofpacket = r_eop;
`ifdef UART_RX_PARITY_EN
  assign parity_error   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frame-level scoreboard of expected strobes plus
// an idle/end-of-packet model, checked every clock on the falling edge.
module tb_uart_rx_oversampled;

  localparam int Bit        = 434;   // clocks per bit at 50 MHz / 115200
  localparam int LatNominal = 4123;  // 9.5 bit times from start edge to ready
  localparam int LatParity  = 4557;  // 10.5 bit times with the parity bit
  localparam int LatTol     = 60;

  typedef struct {
    bit         ferr;
    bit         perr;
    logic [7:0] data;
    int         t0;
    int         lat;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       framing_error;
  logic       rx_idle;
  logic       rx_endofpacket;
  logic       w_perr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_ready = 0;
  int n_ferr  = 0;
  int n_eop   = 0;
  int n_perr  = 0;
  int last_ready_cyc = 0;
  int idle_rise_cyc  = 0;
  ev_t exp_q[$];

  uart_rx_oversampled dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error  (w_perr),
`endif
    .rx_idle       (rx_idle),
    .rx_endofpacket(rx_endofpacket)
  );

`ifndef UART_RX_PARITY_EN
  assign w_perr = 1'b0;
`endif

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic level, input int n);
    rxd = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input bit use_par, input bit expect_it);
    ev_t ev;
    if (expect_it) begin
      ev.ferr = !stop;
      ev.data = d;
      ev.perr = use_par && (par != ^d);
      ev.t0   = cyc;
      ev.lat  = use_par ? LatParity : LatNominal;
      exp_q.push_back(ev);
    end
    drive(1'b0, Bit);
    for (int i = 0; i < 8; i++) drive(d[i], Bit);
    if (use_par) drive(par, Bit);
    drive(stop, Bit);
  endtask

  // Scoreboard and idle/end-of-packet model.
  initial begin : compare
    logic [7:0] m_data;
    bit         m_seen;
    logic       m_prev_idle;
    ev_t        ev;
    int         dt;
    m_data      = 8'h00;
    m_seen      = 1'b0;
    m_prev_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs_zero",
              {rx_data, rx_data_ready, framing_error, rx_idle, rx_endofpacket, w_perr}, '0);
        m_data      = 8'h00;
        m_seen      = 1'b0;
        m_prev_idle = 1'b0;
      end else begin
        check("ready_ferr_exclusive", rx_data_ready & framing_error, 1'b0);
        if (rx_data_ready) n_ready++;
        if (framing_error) n_ferr++;
        if (rx_endofpacket) n_eop++;
        if (rx_data_ready || framing_error) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1'b1, 1'b0);
          end else begin
            ev = exp_q.pop_front();
            dt = cyc - ev.t0;
            check("strobe_kind_ferr", framing_error, ev.ferr);
            check("strobe_latency_in_window",
                  (dt >= ev.lat - LatTol) && (dt <= ev.lat + LatTol), 1'b1);
            if (rx_data_ready) begin
              if (!ev.ferr) m_data = ev.data;
              check("parity_error_value", w_perr, ev.perr);
              if (w_perr) n_perr++;
              m_seen         = 1'b1;
              last_ready_cyc = cyc;
            end
          end
        end else begin
          check("parity_error_without_ready", w_perr, 1'b0);
        end
        check("rx_data_value", rx_data, m_data);
        if (rx_idle && !m_prev_idle) begin
          check("eop_on_idle_rise", rx_endofpacket, m_seen);
          m_seen        = 1'b0;
          idle_rise_cyc = cyc;
        end else begin
          check("eop_without_idle_rise", rx_endofpacket, 1'b0);
        end
        m_prev_idle = rx_idle;
      end
    end
  end

  initial begin : stimulus
    int b_ready, b_ferr, b_eop, b_perr, d_idle;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_ready", rx_data_ready, 1'b0);
    check("reset_rx_idle", rx_idle, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1000);
    check("powerup_idle", rx_idle, 1'b1);
    check("powerup_no_eop", n_eop, 0);

    // 0x55 on an idle line.
    b_ready = n_ready; b_eop = n_eop;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1300);
    d_idle = idle_rise_cyc - last_ready_cyc;
    check("t1_ready_count", n_ready - b_ready, 1);
    check("t1_rx_data", rx_data, 8'h55);
    check("t1_eop_count", n_eop - b_eop, 1);
    check("t1_idle_delay_in_window", (d_idle >= 866) && (d_idle <= 870), 1'b1);
    check("t1_rx_idle", rx_idle, 1'b1);

    // Short low glitch must be rejected.
    b_ready = n_ready; b_ferr = n_ferr; b_eop = n_eop;
    drive(1'b0, 100);
    drive(1'b1, 1300);
    check("t2_no_ready", n_ready - b_ready, 0);
    check("t2_no_ferr", n_ferr - b_ferr, 0);
    check("t2_no_eop", n_eop - b_eop, 0);
    check("t2_rx_idle", rx_idle, 1'b1);

    // Low stop bit with the line held low, then a clean frame.
    b_ready = n_ready; b_ferr = n_ferr; b_eop = n_eop;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2000);
    drive(1'b1, Bit);
    check("t3_ferr_count", n_ferr - b_ferr, 1);
    check("t3_no_ready", n_ready - b_ready, 0);
    check("t3_rx_data_kept", rx_data, 8'h55);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1300);
    check("t3_ready_count", n_ready - b_ready, 1);
    check("t3_rx_data", rx_data, 8'h3C);
    check("t3_eop_count", n_eop - b_eop, 1);

    // Back-to-back frames with no gap.
    b_ready = n_ready; b_eop = n_eop;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1300);
    check("t4_ready_count", n_ready - b_ready, 3);
    check("t4_rx_data", rx_data, 8'h81);
    check("t4_eop_count", n_eop - b_eop, 1);

    // Reset in the middle of data bit 4, release during a high bit.
    b_ready = n_ready; b_ferr = n_ferr; b_eop = n_eop;
    fork
      send_frame(8'hEF, 1'b1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5 * Bit + Bit / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_outputs_in_reset",
              {rx_data, rx_data_ready, framing_error, rx_idle, rx_endofpacket}, '0);
        repeat (2 * Bit - 3) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    drive(1'b1, 1000);
    check("t5_no_strobe_from_abort", (n_ready - b_ready) + (n_ferr - b_ferr), 0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1300);
    check("t5_ready_count", n_ready - b_ready, 1);
    check("t5_rx_data", rx_data, 8'h7E);
    check("t5_eop_count", n_eop - b_eop, 1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    b_ready = n_ready; b_perr = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, Bit);
    check("t6_good_parity_no_error", n_perr - b_perr, 0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1300);
    check("t6_ready_count", n_ready - b_ready, 2);
    check("t6_parity_error_count", n_perr - b_perr, 1);
    check("t6_rx_data", rx_data, 8'h07);
`else
    b_perr = n_perr;
    check("no_parity_errors", n_perr - b_perr, 0);
`endif

    check("expected_strobes_all_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
